multi_phase_driver: RTL

N-channel, phase-shifted complementary PWM generator with per-channel deadtime insertion and glitch-free shadowed reconfiguration. It is the next generation of the single-pair fixed driver. Period, on-time and phase shift are given directly in reference-clock ticks, so no on-chip dividers are needed. It sits between the control CPU/register file and the gate-driver pins: one master counter, N channel comparators, and N high/low output pairs, each with its own deadtime FSM.

---
 rtl/multi_phase_driver.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_phase_driver.sv
// multi_phase_driver: N-channel phase-shifted complementary PWM generator with
// per-channel deadtime and shadowed, wrap-aligned reconfiguration.
module multi_phase_driver #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned CNT_BITS = 24,
  parameter int unsigned DT_BITS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     fault,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CNT_BITS-1:0]      cfg_period,
  input  logic [N_CH*CNT_BITS-1:0] cfg_on,
  input  logic [N_CH*CNT_BITS-1:0] cfg_shift,
  input  logic [DT_BITS-1:0]       cfg_dt,
  output logic [N_CH-1:0]          hi,
  output logic [N_CH-1:0]          lo,
  output logic                     sync,
  output logic                     running,
  output logic                     fault_latched
);
  localparam int unsigned VEC_W = N_CH * CNT_BITS;
  localparam int unsigned LOC_W = CNT_BITS + 1;

  typedef enum logic [1:0] {ST_OFF, ST_LO, ST_DEAD, ST_HI} ch_state_e;

  logic                pending_q, pending_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [CNT_BITS-1:0] shd_period_q, shd_period_d, act_period_q, act_period_d;
  logic [VEC_W-1:0]    shd_on_q, shd_on_d, act_on_q, act_on_d;
  logic [VEC_W-1:0]    shd_shift_q, shd_shift_d, act_shift_q, act_shift_d;
  logic [DT_BITS-1:0]  shd_dt_q, shd_dt_d, act_dt_q, act_dt_d;
  logic                fault_latched_q, fault_latched_d;
  logic                running_q, running_d;
  logic                sync_q, sync_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                cfg_accept, cfg_copy, run_ok, wrap, fsm_go, dt_zero;
  logic [CNT_BITS-1:0] period_m1;
  logic [DT_BITS-1:0]  dt_m1;

  assign period_m1  = act_period_q - CNT_BITS'(1);
  assign dt_m1      = act_dt_q - DT_BITS'(1);
  assign dt_zero    = (act_dt_q == '0);
  assign run_ok     = en && !fault_latched_q && (act_period_q >= CNT_BITS'(2));
  assign wrap       = running_q && (cnt_q >= period_m1);
  assign fsm_go     = run_ok && running_q;
  assign cfg_accept = cfg_valid && !pending_q;
  // Shadow lands in the active set at a wrap, or immediately when idle.
  assign cfg_copy   = pending_q && (!running_q || wrap);

  always_comb begin
    shd_period_d = shd_period_q;
    shd_on_d     = shd_on_q;
    shd_shift_d  = shd_shift_q;
    shd_dt_d     = shd_dt_q;
    act_period_d = act_period_q;
    act_on_d     = act_on_q;
    act_shift_d  = act_shift_q;
    act_dt_d     = act_dt_q;
    pending_d    = pending_q;
    if (cfg_accept) begin
      shd_period_d = cfg_period;
      shd_on_d     = cfg_on;
      shd_shift_d  = cfg_shift;
      shd_dt_d     = cfg_dt;
      pending_d    = 1'b1;
    end
    if (cfg_copy) begin
      act_period_d = shd_period_q;
      act_on_d     = shd_on_q;
      act_shift_d  = shd_shift_q;
      act_dt_d     = shd_dt_q;
      pending_d    = 1'b0;
    end
    cfg_ready_d = !pending_d;
  end

  always_comb begin
    fault_latched_d = en ? (fault_latched_q || fault) : 1'b0;
    running_d       = run_ok;
    cnt_d           = '0;
    if (fsm_go && !wrap) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
    sync_d = run_ok && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q       <= 1'b0;
      cfg_ready_q     <= 1'b1;
      shd_period_q    <= '0;
      shd_on_q        <= '0;
      shd_shift_q     <= '0;
      shd_dt_q        <= '0;
      act_period_q    <= '0;
      act_on_q        <= '0;
      act_shift_q     <= '0;
      act_dt_q        <= '0;
      fault_latched_q <= 1'b0;
      running_q       <= 1'b0;
      sync_q          <= 1'b0;
      cnt_q           <= '0;
    end else begin
      pending_q       <= pending_d;
      cfg_ready_q     <= cfg_ready_d;
      shd_period_q    <= shd_period_d;
      shd_on_q        <= shd_on_d;
      shd_shift_q     <= shd_shift_d;
      shd_dt_q        <= shd_dt_d;
      act_period_q    <= act_period_d;
      act_on_q        <= act_on_d;
      act_shift_q     <= act_shift_d;
      act_dt_q        <= act_dt_d;
      fault_latched_q <= fault_latched_d;
      running_q       <= running_d;
      sync_q          <= sync_d;
      cnt_q           <= cnt_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign sync          = sync_q;
  assign running       = running_q;
  assign fault_latched = fault_latched_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ch_state_e           state_q, state_d;
    ch_state_e           target;
    logic [DT_BITS-1:0]  tmr_q, tmr_d;
    logic                hi_q, lo_q, hi_d, lo_d;
    logic [CNT_BITS-1:0] on_k, shift_k, shift_eff;
    logic [LOC_W-1:0]    local_pos;
    logic                demand;

    assign on_k    = act_on_q[k*CNT_BITS +: CNT_BITS];
    assign shift_k = act_shift_q[k*CNT_BITS +: CNT_BITS];

    // Channel-local position within the period, delayed by the clamped shift.
    always_comb begin
      shift_eff = (shift_k > period_m1) ? period_m1 : shift_k;
      if (cnt_q >= shift_eff) begin
        local_pos = LOC_W'(cnt_q) - LOC_W'(shift_eff);
      end else begin
        local_pos = LOC_W'(cnt_q) + LOC_W'(act_period_q) - LOC_W'(shift_eff);
      end
      demand = (local_pos < LOC_W'(on_k));
      target = demand ? ST_HI : ST_LO;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_OFF;
        tmr_q   <= '0;
        hi_q    <= 1'b0;
        lo_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
        hi_q    <= hi_d;
        lo_q    <= lo_d;
      end
    end

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      if (!fsm_go) begin
        state_d = ST_OFF;
        tmr_d   = '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            if (dt_zero) begin
              state_d = target;
            end else begin
              state_d = ST_DEAD;
              tmr_d   = dt_m1;
            end
          end
          ST_LO: begin
            if (demand) begin
              if (dt_zero) begin
                state_d = ST_HI;
              end else begin
                state_d = ST_DEAD;
                tmr_d   = dt_m1;
              end
            end
          end
          ST_HI: begin
            if (!demand) begin
              if (dt_zero) begin
                state_d = ST_LO;
              end else begin
                state_d = ST_DEAD;
                tmr_d   = dt_m1;
              end
            end
          end
          ST_DEAD: begin
            // Timer runs out regardless of demand toggles; exit follows current demand.
            if (tmr_q == '0) begin
              state_d = target;
            end else begin
              tmr_d = tmr_q - DT_BITS'(1);
            end
          end
          default: state_d = ST_OFF;
        endcase
      end
    end

    always_comb begin
      hi_d = (state_d == ST_HI);
      lo_d = (state_d == ST_LO);
    end

    assign hi[k] = hi_q;
    assign lo[k] = lo_q;
  end

endmodule
